// File: rtl/studio_mem_arbiter_if.sv
// Request/response and memory bus bundle for the studio RAM arbiter.
interface studio_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  // Cartridge loader
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_overrun;
  // Video DMA
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_data;
  logic              dma_valid;
  logic              dma_done;
  // CPU
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ready;
  // Single-port RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;

  // Arbiter side
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_overrun,
    input  dma_req, dma_addr,
    output dma_data, dma_valid, dma_done,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ready,
    output mem_addr, mem_we, mem_din,
    input  mem_dout
  );

  // Requester / RAM side
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_overrun,
    output dma_req, dma_addr,
    input  dma_data, dma_valid, dma_done,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ready,
    input  mem_addr, mem_we, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/studio_mem_arbiter.sv
// Shares one registered single-port RAM bus between the cartridge loader,
// the video DMA line fetcher and the CPU.
module studio_mem_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BURST_LEN = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  studio_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CPU  = 2'd2,
    ST_DMA  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ld_entry_t;

  state_t            state_q, state_d;
  logic              buf_full_q, buf_full_d;
  ld_entry_t         buf_q, buf_d;
  logic              overrun_q, overrun_d;
  logic              fair_cpu_q, fair_cpu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] dma_base_q, dma_base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic              cpu_ready_q, cpu_ready_d;
  // DMA read pipeline: address issued -> RAM data valid -> dma_data out
  logic              issue_vld_q, issue_vld_d;
  logic              issue_last_q, issue_last_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;
  logic [7:0]        dma_data_q, dma_data_d;
  logic              dma_valid_q, dma_valid_d;
  logic              dma_done_q, dma_done_d;

  logic capture;
  logic cpu_ok;

  assign capture = bus.ioctl_wr & bus.ioctl_download;
  assign cpu_ok  = bus.cpu_req & ~bus.ioctl_download;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      buf_full_q   <= 1'b0;
      buf_q        <= '0;
      overrun_q    <= 1'b0;
      fair_cpu_q   <= 1'b0;
      cnt_q        <= '0;
      dma_base_q   <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_din_q    <= '0;
      cpu_dout_q   <= '0;
      cpu_ready_q  <= 1'b0;
      issue_vld_q  <= 1'b0;
      issue_last_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      dma_data_q   <= '0;
      dma_valid_q  <= 1'b0;
      dma_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_full_q   <= buf_full_d;
      buf_q        <= buf_d;
      overrun_q    <= overrun_d;
      fair_cpu_q   <= fair_cpu_d;
      cnt_q        <= cnt_d;
      dma_base_q   <= dma_base_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_din_q    <= mem_din_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_ready_q  <= cpu_ready_d;
      issue_vld_q  <= issue_vld_d;
      issue_last_q <= issue_last_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      dma_data_q   <= dma_data_d;
      dma_valid_q  <= dma_valid_d;
      dma_done_q   <= dma_done_d;
    end
  end

  // Arbitration, access sequencing, loader buffer and DMA read pipeline
  always_comb begin
    state_d      = state_q;
    buf_full_d   = buf_full_q;
    buf_d        = buf_q;
    overrun_d    = overrun_q;
    fair_cpu_d   = fair_cpu_q;
    cnt_d        = cnt_q;
    dma_base_d   = dma_base_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_din_d    = mem_din_q;
    cpu_dout_d   = cpu_dout_q;
    cpu_ready_d  = 1'b0;
    issue_vld_d  = 1'b0;
    issue_last_d = 1'b0;
    rd_vld_d     = issue_vld_q;
    rd_last_d    = issue_last_q;
    dma_valid_d  = rd_vld_q;
    dma_done_d   = rd_last_q;
    dma_data_d   = rd_vld_q ? bus.mem_dout : dma_data_q;

    // A capture always wins over a drain in the same cycle
    if (capture) begin
      buf_d      = '{addr: bus.ioctl_addr, data: bus.ioctl_dout};
      buf_full_d = 1'b1;
      if (buf_full_q && (state_q != ST_LOAD)) overrun_d = 1'b1;
    end else if (state_q == ST_LOAD) begin
      buf_full_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          state_d = ST_LOAD;
        end else if (cpu_ok && (fair_cpu_q || !bus.dma_req)) begin
          state_d    = ST_CPU;
          mem_addr_d = bus.cpu_addr;
          mem_we_d   = bus.cpu_we;
          mem_din_d  = bus.cpu_din;
          cnt_d      = '0;
          fair_cpu_d = 1'b0;
        end else if (bus.dma_req) begin
          state_d      = ST_DMA;
          dma_base_d   = bus.dma_addr;
          mem_addr_d   = bus.dma_addr;
          cnt_d        = CNT_W'(1);
          issue_vld_d  = 1'b1;
          issue_last_d = (BURST_LEN == 32'd1);
        end
      end

      ST_LOAD: begin
        mem_addr_d = buf_q.addr;
        mem_din_d  = buf_q.data;
        mem_we_d   = 1'b1;
        state_d    = ST_IDLE;
      end

      // cnt_q 0: address on bus; cnt_q 1: read data returning
      ST_CPU: begin
        if (cpu_ready_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          if (mem_we_q) cpu_ready_d = 1'b1;
          else          cnt_d       = CNT_W'(1);
        end else begin
          cpu_dout_d  = bus.mem_dout;
          cpu_ready_d = 1'b1;
        end
      end

      // cnt_q is the offset of the next address to issue
      ST_DMA: begin
        if (cnt_q == CNT_W'(BURST_LEN)) begin
          state_d    = ST_IDLE;
          fair_cpu_d = 1'b1;
        end else begin
          mem_addr_d   = dma_base_q + ADDR_W'(cnt_q);
          issue_vld_d  = 1'b1;
          issue_last_d = (cnt_q == CNT_W'(BURST_LEN - 1));
          cnt_d        = CNT_W'(cnt_q + CNT_W'(1));
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ioctl_overrun = overrun_q;
  assign bus.dma_data      = dma_data_q;
  assign bus.dma_valid     = dma_valid_q;
  assign bus.dma_done      = dma_done_q;
  assign bus.cpu_dout      = cpu_dout_q;
  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_din       = mem_din_q;

endmodule

// File: tb/tb_studio_mem_arbiter.sv
// Testbench for studio_mem_arbiter: a behavioural RAM plus a shadow copy of
// its expected contents; scenario tasks compare DUT behaviour against it.
module tb_studio_mem_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BURST  = 8;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  studio_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  studio_mem_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] ram    [4096];
  logic [7:0] shadow [4096];

  int tests_run    = 0;
  int tests_failed = 0;

  // RAM contents: byte i holds i[7:0], except 0x123 which holds 0x5A
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= (i == 'h123) ? 8'h5A : 8'(i);
  end

  // Synchronous single-port RAM, read data one cycle after address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one burst and collect what comes back
  task automatic run_dma(input logic [11:0] a, output logic [7:0] dat [16],
                         output logic [11:0] addrs [16], output int nvalid,
                         output int first_valid, output int done_idx,
                         output int bad_done, output int we_seen);
    nvalid = 0; first_valid = -1; done_idx = -1; bad_done = 0; we_seen = 0;
    for (int i = 0; i < 16; i++) begin dat[i] = '0; addrs[i] = '0; end
    bus.dma_addr = a;
    bus.dma_req  = 1'b1;
    for (int c = 1; c <= int'(BURST) + 6; c++) begin
      tick();
      if (c == 1) bus.dma_req = 1'b0;
      if (c <= int'(BURST)) begin
        addrs[c-1] = bus.mem_addr;
        if (bus.mem_we) we_seen++;
      end
      if (bus.dma_valid) begin
        if (first_valid < 0) first_valid = c;
        if (bus.dma_done) done_idx = nvalid;
        if (nvalid < 16) dat[nvalid] = bus.dma_data;
        nvalid++;
      end else if (bus.dma_done) begin
        bad_done++;
      end
    end
  endtask

  // One CPU access; lat = cycles from request to ready, -1 on timeout
  task automatic run_cpu(input logic we, input logic [11:0] a, input logic [7:0] d,
                         output logic [7:0] dout, output int lat);
    lat = -1; dout = '0;
    bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_req = 1'b1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      tick();
      if (c == 1) bus.cpu_req = 1'b0;
      if (bus.cpu_ready) begin lat = c; dout = bus.cpu_dout; end
    end
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    reset_n = 1'b0;
    repeat (3) tick();
    outs = {bus.ioctl_overrun, bus.dma_data, bus.dma_valid, bus.dma_done, bus.cpu_dout,
            bus.cpu_ready, bus.mem_addr, bus.mem_we, bus.mem_din};
    tests_run++;
    if (outs !== 41'd0) begin
      tests_failed++; $display("FAIL reset_in outs=%h exp=0", outs);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    outs = {bus.ioctl_overrun, bus.dma_data, bus.dma_valid, bus.dma_done, bus.cpu_dout,
            bus.cpu_ready, bus.mem_addr, bus.mem_we, bus.mem_din};
    tests_run++;
    if (outs !== 41'd0) begin
      tests_failed++; $display("FAIL reset_idle outs=%h exp=0", outs);
    end
  endtask

  task automatic test_cpu_read();
    bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123; bus.cpu_req = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    tests_run++;
    if (bus.mem_addr !== 12'h123 || bus.mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_rd_addr got=%h we=%b exp=123 we=0", bus.mem_addr, bus.mem_we);
    end
    tick();
    tests_run++;
    if (bus.cpu_ready !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_rd_early_ready got=%b exp=0", bus.cpu_ready);
    end
    tick();
    tests_run++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_dout !== 8'h5A) begin
      tests_failed++; $display("FAIL cpu_rd_ready got ready=%b dout=%h exp ready=1 dout=5a", bus.cpu_ready, bus.cpu_dout);
    end
    tick();
    tests_run++;
    if (bus.cpu_ready !== 1'b0 || bus.cpu_dout !== 8'h5A) begin
      tests_failed++; $display("FAIL cpu_rd_pulse got ready=%b dout=%h exp ready=0 dout=5a", bus.cpu_ready, bus.cpu_dout);
    end
    tick();
  endtask

  task automatic test_cpu_write();
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'h010; bus.cpu_din = 8'hA5; bus.cpu_req = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    tests_run++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h010 || bus.mem_din !== 8'hA5) begin
      tests_failed++; $display("FAIL cpu_wr_bus got we=%b addr=%h din=%h exp 1/010/a5", bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    tick();
    tests_run++;
    if (bus.cpu_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_wr_ready got ready=%b we=%b exp ready=1 we=0", bus.cpu_ready, bus.mem_we);
    end
    shadow[12'h010] = 8'hA5;
    repeat (2) tick();
    tests_run++;
    if (ram[12'h010] !== 8'hA5) begin
      tests_failed++; $display("FAIL cpu_wr_ram got=%h exp=a5", ram[12'h010]);
    end
  endtask

  task automatic test_dma_wrap();
    logic [7:0]  dat [16];
    logic [11:0] addrs [16];
    int nv, fv, di, bd, ws;
    run_dma(12'hFFC, dat, addrs, nv, fv, di, bd, ws);
    tests_run++;
    if (nv !== int'(BURST) || fv !== 3 || di !== int'(BURST) - 1 || bd !== 0 || ws !== 0) begin
      tests_failed++;
      $display("FAIL dma_wrap_shape got n=%0d first=%0d done=%0d stray=%0d we=%0d exp 8/3/7/0/0", nv, fv, di, bd, ws);
    end
    for (int i = 0; i < int'(BURST); i++) begin
      logic [11:0] ea;
      ea = 12'(12'hFFC + i);
      tests_run++;
      if (addrs[i] !== ea || dat[i] !== ea[7:0]) begin
        tests_failed++; $display("FAIL dma_wrap_beat%0d got addr=%h data=%h exp %h/%h", i, addrs[i], dat[i], ea, ea[7:0]);
      end
    end
  endtask

  task automatic test_fairness();
    byte unsigned log_q [$];
    int dd;
    bus.dma_addr = 12'h200; bus.dma_req = 1'b1;
    tick();
    bus.cpu_we = 1'b0; bus.cpu_addr = 12'h050; bus.cpu_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.dma_done)  log_q.push_back("D");
      if (bus.cpu_ready) log_q.push_back("C");
    end
    bus.dma_req = 1'b0; bus.cpu_req = 1'b0;
    repeat (20) tick();
    tests_run++;
    if (log_q.size() < 3) begin
      tests_failed++; $display("FAIL fair_events got=%0d exp>=3", log_q.size());
    end else if (log_q[0] !== "D" || log_q[1] !== "C" || log_q[2] !== "D") begin
      tests_failed++; $display("FAIL fair_order got=%c%c%c exp=DCD", log_q[0], log_q[1], log_q[2]);
    end
    dd = 0;
    for (int i = 1; i < log_q.size(); i++) if (log_q[i] == "D" && log_q[i-1] == "D") dd++;
    tests_run++;
    if (dd !== 0) begin
      tests_failed++; $display("FAIL fair_starve back_to_back_bursts=%0d exp=0", dd);
    end
  endtask

  // Loader strobes during a DMA burst; n_strobes is 1 or 2
  task automatic loader_during_burst(input int n_strobes, output int nwr, output int first_c,
                                     output logic [11:0] wa, output logic [7:0] wd);
    nwr = 0; first_c = -1; wa = '0; wd = '0;
    bus.ioctl_download = 1'b1;
    tick();
    bus.dma_addr = 12'h600; bus.dma_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) bus.dma_req = 1'b0;
      if (c == 3) begin
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = (n_strobes == 1) ? 12'h400 : 12'h401;
        bus.ioctl_dout = (n_strobes == 1) ? 8'h77 : 8'h11;
      end
      if (c == 4) bus.ioctl_wr = 1'b0;
      if (c == 5 && n_strobes == 2) begin
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 12'h402; bus.ioctl_dout = 8'h22;
      end
      if (c == 6) bus.ioctl_wr = 1'b0;
      if (bus.mem_we) begin
        nwr++; wa = bus.mem_addr; wd = bus.mem_din;
        if (first_c < 0) first_c = c;
      end
    end
  endtask

  task automatic test_loader_single();
    int nwr, fc;
    logic [11:0] wa;
    logic [7:0]  wd;
    loader_during_burst(1, nwr, fc, wa, wd);
    shadow[12'h400] = 8'h77;
    tests_run++;
    if (nwr !== 1 || wa !== 12'h400 || wd !== 8'h77) begin
      tests_failed++; $display("FAIL load_single got n=%0d addr=%h data=%h exp 1/400/77", nwr, wa, wd);
    end
    tests_run++;
    if (fc !== int'(BURST) + 3) begin
      tests_failed++; $display("FAIL load_after_burst got cycle=%0d exp=%0d", fc, BURST + 3);
    end
    tests_run++;
    if (bus.ioctl_overrun !== 1'b0) begin
      tests_failed++; $display("FAIL load_no_overrun got=%b exp=0", bus.ioctl_overrun);
    end
  endtask

  task automatic test_loader_overrun();
    int nwr, fc;
    logic [11:0] wa;
    logic [7:0]  wd;
    loader_during_burst(2, nwr, fc, wa, wd);
    shadow[12'h402] = 8'h22;
    tests_run++;
    if (nwr !== 1 || wa !== 12'h402 || wd !== 8'h22) begin
      tests_failed++; $display("FAIL load_overwrite got n=%0d addr=%h data=%h exp 1/402/22", nwr, wa, wd);
    end
    tests_run++;
    if (bus.ioctl_overrun !== 1'b1 || ram[12'h401] !== shadow[12'h401]) begin
      tests_failed++; $display("FAIL load_overrun got ovr=%b ram401=%h exp 1/%h", bus.ioctl_overrun, ram[12'h401], shadow[12'h401]);
    end
  endtask

  task automatic test_download_blocks_cpu();
    int nready, lat, nwr;
    nready = 0; lat = -1; nwr = 0;
    bus.ioctl_download = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'h300; bus.cpu_din = 8'h3C; bus.cpu_req = 1'b1;
    repeat (10) begin
      tick();
      if (bus.cpu_ready) nready++;
    end
    tests_run++;
    if (nready !== 0) begin
      tests_failed++; $display("FAIL dl_blocks_cpu got ready_pulses=%0d exp=0", nready);
    end
    bus.ioctl_download = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.cpu_ready && lat < 0) begin lat = c; bus.cpu_req = 1'b0; end
    end
    bus.cpu_req = 1'b0;
    shadow[12'h300] = 8'h3C;
    tests_run++;
    if (lat < 1 || lat > 3 || ram[12'h300] !== 8'h3C) begin
      tests_failed++; $display("FAIL dl_release got lat=%0d ram=%h exp lat<=3 ram=3c", lat, ram[12'h300]);
    end
    // Strobe without download active must be ignored
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 12'h500; bus.ioctl_dout = 8'hEE;
    tick();
    bus.ioctl_wr = 1'b0;
    repeat (6) begin
      tick();
      if (bus.mem_we) nwr++;
    end
    tests_run++;
    if (nwr !== 0 || ram[12'h500] !== shadow[12'h500]) begin
      tests_failed++; $display("FAIL wr_no_download got writes=%0d ram=%h exp 0/%h", nwr, ram[12'h500], shadow[12'h500]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0]  dat [16];
    logic [11:0] addrs [16];
    int nv, fv, di, bd, ws;
    bus.dma_addr = 12'h0F0; bus.dma_req = 1'b1;
    tick();
    bus.dma_req = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (bus.dma_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rst_burst_active got valid=%b exp=1", bus.dma_valid);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.dma_valid, bus.dma_done, bus.ioctl_overrun, bus.mem_we, bus.cpu_ready} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_abort got valid=%b done=%b ovr=%b we=%b rdy=%b exp all 0",
               bus.dma_valid, bus.dma_done, bus.ioctl_overrun, bus.mem_we, bus.cpu_ready);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    run_dma(12'h0A0, dat, addrs, nv, fv, di, bd, ws);
    tests_run++;
    if (nv !== int'(BURST) || fv !== 3 || di !== int'(BURST) - 1 || bd !== 0) begin
      tests_failed++; $display("FAIL rst_clean_burst got n=%0d first=%0d done=%0d stray=%0d exp 8/3/7/0", nv, fv, di, bd);
    end
    for (int i = 0; i < int'(BURST); i++) begin
      tests_run++;
      if (dat[i] !== shadow[12'(12'h0A0 + i)]) begin
        tests_failed++; $display("FAIL rst_clean_data%0d got=%h exp=%h", i, dat[i], shadow[12'(12'h0A0 + i)]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  dat [16];
    logic [11:0] addrs [16];
    logic [11:0] a;
    logic [7:0]  d, dout;
    int nv, fv, di, bd, ws, lat, op, bad;
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 2));
      a  = 12'($urandom);
      d  = 8'($urandom);
      if (op == 0) begin
        run_cpu(1'b1, a, d, dout, lat);
        shadow[a] = d;
        tests_run++;
        if (lat !== 2) begin
          tests_failed++; $display("FAIL rand_wr addr=%h got lat=%0d exp=2", a, lat);
        end
      end else if (op == 1) begin
        run_cpu(1'b0, a, d, dout, lat);
        tests_run++;
        if (lat !== 3 || dout !== shadow[a]) begin
          tests_failed++; $display("FAIL rand_rd addr=%h got lat=%0d data=%h exp 3/%h", a, lat, dout, shadow[a]);
        end
      end else begin
        run_dma(a, dat, addrs, nv, fv, di, bd, ws);
        bad = 0;
        for (int i = 0; i < int'(BURST); i++) begin
          if (dat[i] !== shadow[12'(a + i)] || addrs[i] !== 12'(a + i)) bad++;
        end
        tests_run++;
        if (nv !== int'(BURST) || fv !== 3 || di !== int'(BURST) - 1 || bd !== 0 || ws !== 0 || bad !== 0) begin
          tests_failed++;
          $display("FAIL rand_dma addr=%h got n=%0d first=%0d done=%0d bad_beats=%0d exp 8/3/7/0", a, nv, fv, di, bad);
        end
      end
      repeat (2) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = (i == 'h123) ? 8'h5A : 8'(i);
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    bus.dma_req = 1'b0; bus.dma_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;

    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dma_wrap();
    test_fairness();
    test_loader_single();
    test_loader_overrun();
    test_download_blocks_cpu();
    test_reset_mid_burst();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/studio_mem_arbiter.md
Name: studio_mem_arbiter

Overview:
- Shares the single-port cartridge/system RAM of the rcastudioii core between three requesters: the ioctl cartridge loader, the video DMA engine (8-byte line fetches) and the CPU.
- Sequences all accesses on one registered memory bus.
- Stalls the CPU through a ready pulse.
- Buffers one loader write so no download byte is lost during a DMA burst.

Parameters:
- ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W.
- BURST_LEN, 8, bytes per DMA burst (1..16).

Ports:
- clk  in  1  system clock (clk_sys domain)
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  cartridge download active
- ioctl_wr  in  1  single-cycle loader write strobe
- ioctl_addr  in  ADDR_W  loader write address
- ioctl_dout  in  8  loader write data
- ioctl_overrun  out  1  sticky: a buffered loader write was overwritten
- dma_req  in  1  request one burst (level, sampled in IDLE)
- dma_addr  in  ADDR_W  burst start address
- dma_data  out  8  burst read data
- dma_valid  out  1  dma_data valid this cycle
- dma_done  out  1  pulse coincident with last dma_valid
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- cpu_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_din  out  8  RAM write data (registered)
- mem_dout  in  8  RAM read data, valid one cycle after mem_addr

Behaviour:
- Reset: all outputs 0, state IDLE, loader buffer empty, fairness flag clear. Reset mid-burst or mid-access aborts it; no further pulses are produced.
- States: IDLE, LOAD, CPU, DMA.
- Loader buffer: ioctl_wr with ioctl_download=1 captures addr/data into a 1-entry buffer.
  - If the buffer is already full and not drained the same cycle, the new entry overwrites it and ioctl_overrun sets. It clears only on reset.
  - ioctl_wr with ioctl_download=0 is ignored.
- IDLE arbitration, one grant per cycle, priority order:
  1. Buffer full -> LOAD.
  2. fair_cpu & cpu_req & ~ioctl_download -> CPU.
  3. dma_req -> DMA.
  4. cpu_req & ~ioctl_download -> CPU.
- fair_cpu sets when a DMA burst completes and clears when CPU is granted. This guarantees the CPU one slot between back-to-back bursts.
- LOAD, 1 cycle:
  - Next cycle mem_we=1 with buffer addr/data; buffer empties; return to IDLE.
  - A capture in the same cycle as the drain refills the buffer; no overrun.
- CPU, granted at cycle N:
  - Cycle N+1: mem_addr=cpu_addr, mem_we=cpu_we, mem_din=cpu_din, all latched at N.
  - Write: cpu_ready pulses at N+2.
  - Read: cpu_dout is registered from mem_dout at N+2 and cpu_ready pulses at N+3, with cpu_dout held until the next CPU read.
  - Return to IDLE after the ready pulse. The access completes even if cpu_req drops after N.
- DMA, granted at cycle N:
  - mem_addr = dma_addr+i (modulo 2^ADDR_W) at cycles N+1..N+BURST_LEN, with mem_we=0.
  - dma_valid is high for BURST_LEN consecutive cycles N+3..N+BURST_LEN+2, dma_data registered.
  - dma_done pulses at N+BURST_LEN+2. A burst is never pre-empted.
  - The IDLE re-entry cycle arbitrates again while the read pipeline drains.
- mem_we is 0 in every cycle not named above; mem_addr holds its last value.
- Loader writes that arrive during CPU/DMA wait in the buffer and are drained at the next IDLE.

Test Plan:
- Reset -> all outputs 0. CPU read of addr 0x123 holding 0x5A -> mem_addr=0x123 at N+1, cpu_ready pulse with cpu_dout=0x5A at N+3. CPU write 0xA5 to 0x010 -> mem_we=1 at N+1, cpu_ready at N+2.
- dma_req at 0xFFC, BURST_LEN=8, RAM[i]=i[7:0] -> addresses 0xFFC..0xFFF,0x000..0x003; dma_data FC,FD,FE,FF,00,01,02,03 on 8 consecutive dma_valid cycles; dma_done on the 8th.
- dma_req held high with cpu_req asserted -> order DMA burst, one CPU access, DMA burst; the CPU is never starved.
- ioctl_download=1 with ioctl_wr at 0x400 during a burst -> write to 0x400 issued right after the burst; ioctl_overrun=0. Two strobes during a burst -> only the second write reaches memory and ioctl_overrun=1.
- ioctl_download=1 with cpu_req held -> no cpu_ready while downloading. The access is served within 3 cycles after download drops (no other requests pending).
- reset_n asserted 3 cycles into a burst -> dma_valid/dma_done go to 0 immediately. After release, a new dma_req produces a full clean burst.
